// File: rtl/seq_stage_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the Y86-64 SEQ stage sequencer:
//   - icode constants (HALT .. POPQ)
//   - architectural Stat codes (AOK, HLT, ADR, INS)
//   - sequencer state encoding
//   - needs_mem(icode) / needs_wb(icode): which optional stages an
//     instruction visits
// No ports (package).
// ----------------------------------------------------------------------------
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'd0;
    localparam logic [3:0] ICODE_NOP    = 4'd1;
    localparam logic [3:0] ICODE_CMOVXX = 4'd2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'd3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'd4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'd5;
    localparam logic [3:0] ICODE_OPQ    = 4'd6;
    localparam logic [3:0] ICODE_JXX    = 4'd7;
    localparam logic [3:0] ICODE_CALL   = 4'd8;
    localparam logic [3:0] ICODE_RET    = 4'd9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'd10;
    localparam logic [3:0] ICODE_POPQ   = 4'd11;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_EXECUTE   = 4'd3,
        ST_MEMORY    = 4'd4,
        ST_WRITEBACK = 4'd5,
        ST_PCUPDATE  = 4'd6,
        ST_HALT      = 4'd7,
        ST_ERROR     = 4'd8
    } state_e;

    // Instructions that touch data memory (loads, stores, stack ops).
    function automatic logic needs_mem(input logic [3:0] icode);
        return icode inside {ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_CALL,
                             ICODE_RET, ICODE_PUSHQ, ICODE_POPQ};
    endfunction

    // Instructions that write the register file. cmovXX is included; the
    // register file itself suppresses the write when Cnd is false.
    function automatic logic needs_wb(input logic [3:0] icode);
        logic wb;
        case (icode)
            ICODE_HALT, ICODE_NOP, ICODE_RMMOVQ, ICODE_JXX: wb = 1'b0;
            default:                                        wb = (icode <= ICODE_POPQ);
        endcase
        return wb;
    endfunction

endpackage

// File: rtl/seq_stage_ctrl_if.sv
// ----------------------------------------------------------------------------
// seq_stage_ctrl_if
// Handshake bundle between the SEQ sequencer and its datapath.
//   Datapath -> sequencer: start, imem_valid, imem_error, icode[3:0],
//                          dmem_ready, dmem_error
//   Sequencer -> datapath: fetch_en, decode_en, exec_en, mem_req, wb_en,
//                          pc_en, stat[2:0], busy
// Modports:
//   master - datapath / environment side
//   slave  - sequencer side (seq_stage_ctrl)
// ----------------------------------------------------------------------------
interface seq_stage_ctrl_if;

    logic       start;
    logic       imem_valid;
    logic       imem_error;
    logic [3:0] icode;
    logic       dmem_ready;
    logic       dmem_error;

    logic       fetch_en;
    logic       decode_en;
    logic       exec_en;
    logic       mem_req;
    logic       wb_en;
    logic       pc_en;
    logic [2:0] stat;
    logic       busy;

    modport master (
        output start, imem_valid, imem_error, icode, dmem_ready, dmem_error,
        input  fetch_en, decode_en, exec_en, mem_req, wb_en, pc_en, stat, busy
    );

    modport slave (
        input  start, imem_valid, imem_error, icode, dmem_ready, dmem_error,
        output fetch_en, decode_en, exec_en, mem_req, wb_en, pc_en, stat, busy
    );

endinterface

// File: rtl/seq_stage_ctrl.sv
// ----------------------------------------------------------------------------
// seq_stage_ctrl
// Multi-cycle sequencer for the Y86-64 SEQ datapath. Walks one instruction
// through FETCH, DECODE, EXECUTE, [MEMORY], WRITEBACK, PCUPDATE, giving each
// stage its enable, skipping MEMORY for icodes that do not need it, timing
// out stalled memory transfers and tracking the architectural Stat code.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - synchronous active-low reset
//   bus        - seq_stage_ctrl_if.slave handshake bundle
//   cycle_cnt  - busy-cycle counter        (SEQ_PERF_CNT_EN only)
//   instr_cnt  - retired-instruction count (SEQ_PERF_CNT_EN only)
//
// Parameters:
//   MEM_TIMEOUT - cycles MEMORY waits for dmem_ready before ADR (1..255)
//   CNT_W       - performance counter width (SEQ_PERF_CNT_EN only)
//
// Build option:
//   SEQ_PERF_CNT_EN - when defined, adds the cycle_cnt / instr_cnt counters.
// ----------------------------------------------------------------------------
module seq_stage_ctrl
    import y86_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
`ifdef SEQ_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_stage_ctrl_if.slave bus
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    // Value of the wait counter during the last permitted MEMORY cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [2:0] stat_q, stat_d;
    logic [3:0] icode_q, icode_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    logic fetch_en;
    logic decode_en;
    logic exec_en;
    logic mem_req;
    logic wb_en;
    logic pc_en;
    logic busy;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            stat_q     <= STAT_AOK;
            icode_q    <= ICODE_NOP;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            stat_q     <= stat_d;
            icode_q    <= icode_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        stat_d     = stat_q;
        icode_d    = icode_q;
        wait_cnt_d = '0;   // cleared everywhere except while waiting in MEMORY

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (bus.imem_valid) begin
                    // icode is captured so later stages do not depend on the
                    // fetch unit holding it.
                    icode_d = bus.icode;
                    if (bus.imem_error) begin
                        state_d = ST_ERROR;
                        stat_d  = STAT_ADR;
                    end else if (bus.icode > ICODE_POPQ) begin
                        state_d = ST_ERROR;
                        stat_d  = STAT_INS;
                    end else if (bus.icode == ICODE_HALT) begin
                        state_d = ST_HALT;
                        stat_d  = STAT_HLT;
                    end else begin
                        state_d = ST_DECODE;
                    end
                end
            end

            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end

            ST_EXECUTE: begin
                state_d = needs_mem(icode_q) ? ST_MEMORY : ST_WRITEBACK;
            end

            ST_MEMORY: begin
                // dmem_ready is tested first so a completion on the final
                // permitted cycle still succeeds.
                if (bus.dmem_ready) begin
                    if (bus.dmem_error) begin
                        state_d = ST_ERROR;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_ERROR;
                    stat_d  = STAT_ADR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            ST_WRITEBACK: begin
                state_d = ST_PCUPDATE;
            end

            ST_PCUPDATE: begin
                state_d = bus.start ? ST_FETCH : ST_IDLE;
            end

            ST_HALT, ST_ERROR: begin
                // Terminal: only reset leaves.
            end

            default: begin
                state_d = ST_ERROR;
                stat_d  = STAT_INS;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore: current state plus the captured icode)
    // ------------------------------------------------------------------
    always_comb begin
        fetch_en  = 1'b0;
        decode_en = 1'b0;
        exec_en   = 1'b0;
        mem_req   = 1'b0;
        wb_en     = 1'b0;
        pc_en     = 1'b0;
        busy      = 1'b1;

        case (state_q)
            ST_FETCH:     fetch_en  = 1'b1;
            ST_DECODE:    decode_en = 1'b1;
            ST_EXECUTE:   exec_en   = 1'b1;
            ST_MEMORY:    mem_req   = 1'b1;
            ST_WRITEBACK: wb_en     = needs_wb(icode_q);
            ST_PCUPDATE:  pc_en     = 1'b1;
            default:      busy      = 1'b0;
        endcase
    end

    assign bus.fetch_en  = fetch_en;
    assign bus.decode_en = decode_en;
    assign bus.exec_en   = exec_en;
    assign bus.mem_req   = mem_req;
    assign bus.wb_en     = wb_en;
    assign bus.pc_en     = pc_en;
    assign bus.busy      = busy;
    assign bus.stat      = stat_q;

`ifdef SEQ_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters; both wrap naturally at 2^CNT_W.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] instr_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (busy) begin
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
            end
            if (pc_en) begin
                instr_cnt_q <= instr_cnt_q + 1'b1;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seq_stage_ctrl
// Self-checking bench for seq_stage_ctrl. Inputs change on the falling edge,
// outputs are observed on the falling edge. Expected behaviour comes from a
// per-instruction model (stage counts, latency, final Stat) built from the
// Y86 stage rules. Build with SEQ_PERF_CNT_EN defined to cover the counters.
// ----------------------------------------------------------------------------
module tb_seq_stage_ctrl;

    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_stage_ctrl_if bus ();

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    seq_stage_ctrl #(
        .MEM_TIMEOUT(TIMEOUT)
`ifdef SEQ_PERF_CNT_EN
        , .CNT_W(32)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef SEQ_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt)
        , .instr_cnt(instr_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Observed per-instruction results
    int n_dec, n_exe, n_mem, n_wb, n_pc, lat, n_multi;
    bit stuck;
    // Expected per-instruction results
    int e_dec, e_exe, e_mem, e_wb, e_pc, e_lat, e_stat;

    // ------------------------------------------------------------------
    // Reference model: what one instruction should do, from the ISA rules.
    // waits < 0 means dmem_ready never arrives.
    // ------------------------------------------------------------------
    function automatic void model(input int ic, input bit ierr, input int waits, input bit derr,
                                  output int o_dec, output int o_exe, output int o_mem,
                                  output int o_wb, output int o_pc, output int o_lat,
                                  output int o_stat);
        bit uses_mem;
        bit writes_reg;
        o_dec = 0; o_exe = 0; o_mem = 0; o_wb = 0; o_pc = 0; o_lat = -1; o_stat = 1;
        if (ierr)    begin o_stat = 3; return; end
        if (ic > 11) begin o_stat = 4; return; end
        if (ic == 0) begin o_stat = 2; return; end
        uses_mem   = (ic == 4) || (ic == 5) || (ic >= 8);
        writes_reg = (ic == 2) || (ic == 3) || (ic == 5) || (ic == 6) || (ic >= 8);
        o_dec = 1;
        o_exe = 1;
        if (!uses_mem) begin
            o_wb = int'(writes_reg); o_pc = 1; o_lat = 4;
            return;
        end
        if (waits < 0 || waits >= TIMEOUT) begin
            o_mem = TIMEOUT; o_stat = 3;
            return;
        end
        o_mem = waits + 1;
        if (derr) begin o_stat = 3; return; end
        o_wb = int'(writes_reg); o_pc = 1; o_lat = 5 + waits;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------
    task automatic clear_inputs();
        bus.imem_valid = 1'b0;
        bus.imem_error = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.dmem_error = 1'b0;
    endtask

    task automatic do_reset();
        bus.start = 1'b0;
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_run();
        bus.start = 1'b1;
        @(negedge clk);
    endtask

    // Called with FETCH visible. Presents one instruction, answers the data
    // memory after 'waits' MEMORY cycles, and records what the DUT did until
    // pc_en or a non-busy state. With noise set, spurious imem_valid and
    // dmem_ready are driven outside their owning states.
    task automatic drive_instr(input logic [3:0] ic, input bit ierr, input int waits,
                               input bit derr, input bit drop_start, input bit noise);
        int t;
        int m;
        int en;
        bit done;
        n_dec = 0; n_exe = 0; n_mem = 0; n_wb = 0; n_pc = 0;
        lat = -1; n_multi = 0; stuck = 1'b0;
        t = 0; m = 0; done = 1'b0;
        bus.icode      = ic;
        bus.imem_valid = 1'b1;
        bus.imem_error = ierr;
        bus.dmem_ready = 1'b0;
        bus.dmem_error = 1'b0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
            en = int'(bus.fetch_en) + int'(bus.decode_en) + int'(bus.exec_en) +
                 int'(bus.mem_req) + int'(bus.wb_en) + int'(bus.pc_en);
            if (en > 1) n_multi++;
            n_dec += int'(bus.decode_en);
            n_exe += int'(bus.exec_en);
            n_mem += int'(bus.mem_req);
            n_wb  += int'(bus.wb_en);
            n_pc  += int'(bus.pc_en);
            bus.imem_valid = noise && ($urandom_range(0, 1) == 1);
            bus.imem_error = noise && ($urandom_range(0, 1) == 1);
            if (bus.mem_req) begin
                bus.dmem_ready = (m == waits);
                bus.dmem_error = derr;
                m++;
            end else begin
                bus.dmem_ready = noise && ($urandom_range(0, 1) == 1);
                bus.dmem_error = noise && ($urandom_range(0, 1) == 1);
            end
            if (drop_start && bus.exec_en) bus.start = 1'b0;
            if (bus.pc_en) begin
                lat  = t;
                done = 1'b1;
            end else if (!bus.busy) begin
                done = 1'b1;
            end
        end
        if (!done) stuck = 1'b1;
        if (lat >= 0) @(negedge clk);
        clear_inputs();
        $display("txn icode=%0d ierr=%0d waits=%0d derr=%0d dec=%0d exe=%0d mem=%0d wb=%0d pc=%0d lat=%0d stat=%0d",
                 ic, ierr, waits, derr, n_dec, n_exe, n_mem, n_wb, n_pc, lat, bus.stat);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [5:0] ens;
        bus.start = 1'b0;
        clear_inputs();
        bus.icode = 4'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ens = {bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_req, bus.wb_en, bus.pc_en};
        total++;
        if (ens !== 6'b0) begin bad++; $display("FAIL reset_enables got=%b exp=000000", ens); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++;
        if (bus.stat !== 3'd1) begin bad++; $display("FAIL reset_stat got=%0d exp=1", bus.stat); end
    endtask

    task automatic test_opq();
        start_run();
        total++;
        if (bus.fetch_en !== 1'b1) begin bad++; $display("FAIL opq_fetch got=%b exp=1", bus.fetch_en); end
        model(6, 0, 0, 0, e_dec, e_exe, e_mem, e_wb, e_pc, e_lat, e_stat);
        drive_instr(4'd6, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        total++;
        if (n_dec !== e_dec || n_exe !== e_exe || n_wb !== e_wb || n_pc !== e_pc)
            begin bad++; $display("FAIL opq_stages got=%0d%0d%0d%0d exp=%0d%0d%0d%0d", n_dec, n_exe, n_wb, n_pc, e_dec, e_exe, e_wb, e_pc); end
        total++;
        if (n_mem !== e_mem) begin bad++; $display("FAIL opq_mem_req got=%0d exp=%0d", n_mem, e_mem); end
        total++;
        if (lat !== e_lat) begin bad++; $display("FAIL opq_latency got=%0d exp=%0d", lat, e_lat); end
        total++;
        if (n_multi !== 0) begin bad++; $display("FAIL opq_onehot got=%0d exp=0", n_multi); end
        total++;
        if (bus.fetch_en !== 1'b1 || bus.stat !== 3'd1)
            begin bad++; $display("FAIL opq_refetch got=%b/%0d exp=1/1", bus.fetch_en, bus.stat); end
    endtask

    task automatic test_mem_wait();
        model(5, 0, 3, 0, e_dec, e_exe, e_mem, e_wb, e_pc, e_lat, e_stat);
        drive_instr(4'd5, 1'b0, 3, 1'b0, 1'b0, 1'b0);
        total++;
        if (n_mem !== e_mem) begin bad++; $display("FAIL mrmovq_mem_req got=%0d exp=%0d", n_mem, e_mem); end
        total++;
        if (lat !== e_lat) begin bad++; $display("FAIL mrmovq_latency got=%0d exp=%0d", lat, e_lat); end
        total++;
        if (n_wb !== e_wb || n_pc !== e_pc) begin bad++; $display("FAIL mrmovq_wb_pc got=%0d/%0d exp=%0d/%0d", n_wb, n_pc, e_wb, e_pc); end
        // Ready on the very last permitted cycle must still succeed.
        model(10, 0, TIMEOUT - 1, 0, e_dec, e_exe, e_mem, e_wb, e_pc, e_lat, e_stat);
        drive_instr(4'd10, 1'b0, TIMEOUT - 1, 1'b0, 1'b0, 1'b0);
        total++;
        if (lat !== e_lat || n_mem !== e_mem)
            begin bad++; $display("FAIL ready_at_timeout got=lat%0d/mem%0d exp=lat%0d/mem%0d", lat, n_mem, e_lat, e_mem); end
        total++;
        if (bus.stat !== 3'(e_stat)) begin bad++; $display("FAIL ready_at_timeout_stat got=%0d exp=%0d", bus.stat, e_stat); end
    endtask

    task automatic test_timeout();
        model(4, 0, -1, 0, e_dec, e_exe, e_mem, e_wb, e_pc, e_lat, e_stat);
        drive_instr(4'd4, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        total++;
        if (n_mem !== e_mem) begin bad++; $display("FAIL timeout_mem_req got=%0d exp=%0d", n_mem, e_mem); end
        total++;
        if (n_wb !== 0 || n_pc !== 0) begin bad++; $display("FAIL timeout_wb_pc got=%0d/%0d exp=0/0", n_wb, n_pc); end
        total++;
        if (bus.stat !== 3'(e_stat) || bus.busy !== 1'b0)
            begin bad++; $display("FAIL timeout_stat got=%0d/busy%b exp=%0d/busy0", bus.stat, bus.busy, e_stat); end
        repeat (3) @(negedge clk);
        total++;
        if (bus.mem_req !== 1'b0 || bus.fetch_en !== 1'b0 || bus.stat !== 3'd3)
            begin bad++; $display("FAIL error_terminal got=mem%b/fetch%b/stat%0d exp=0/0/3", bus.mem_req, bus.fetch_en, bus.stat); end
        // dmem_error on completion
        do_reset();
        start_run();
        model(9, 0, 2, 1, e_dec, e_exe, e_mem, e_wb, e_pc, e_lat, e_stat);
        drive_instr(4'd9, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        total++;
        if (bus.stat !== 3'(e_stat) || n_mem !== e_mem || n_pc !== 0)
            begin bad++; $display("FAIL dmem_error got=stat%0d/mem%0d/pc%0d exp=stat%0d/mem%0d/pc0", bus.stat, n_mem, n_pc, e_stat, e_mem); end
    endtask

    task automatic test_terminal();
        logic [3:0] ics [3];
        bit errs [3];
        ics[0] = 4'd0;  errs[0] = 1'b0;
        ics[1] = 4'd13; errs[1] = 1'b0;
        ics[2] = 4'd6;  errs[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_reset();
            start_run();
            model(int'(ics[i]), errs[i], 0, 0, e_dec, e_exe, e_mem, e_wb, e_pc, e_lat, e_stat);
            drive_instr(ics[i], errs[i], 0, 1'b0, 1'b0, 1'b0);
            total++;
            if (bus.stat !== 3'(e_stat)) begin bad++; $display("FAIL terminal_stat icode=%0d got=%0d exp=%0d", ics[i], bus.stat, e_stat); end
            total++;
            if (n_dec !== 0 || bus.busy !== 1'b0)
                begin bad++; $display("FAIL terminal_quiet icode=%0d got=dec%0d/busy%b exp=dec0/busy0", ics[i], n_dec, bus.busy); end
        end
    endtask

    task automatic test_start_drop();
        int late_fetch;
        do_reset();
        start_run();
        model(7, 0, 0, 0, e_dec, e_exe, e_mem, e_wb, e_pc, e_lat, e_stat);
        drive_instr(4'd7, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        total++;
        if (n_wb !== e_wb || n_pc !== e_pc || lat !== e_lat)
            begin bad++; $display("FAIL jxx_drop got=wb%0d/pc%0d/lat%0d exp=wb%0d/pc%0d/lat%0d", n_wb, n_pc, lat, e_wb, e_pc, e_lat); end
        late_fetch = int'(bus.fetch_en) + int'(bus.busy);
        repeat (3) begin
            @(negedge clk);
            late_fetch += int'(bus.fetch_en);
        end
        total++;
        if (late_fetch !== 0) begin bad++; $display("FAIL jxx_idle got=%0d exp=0", late_fetch); end
    endtask

    task automatic test_reset_in_mem();
        // Reset from a terminal error restores AOK.
        do_reset();
        start_run();
        drive_instr(4'd15, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (bus.stat !== 3'd1 || bus.busy !== 1'b0)
            begin bad++; $display("FAIL reset_from_error got=stat%0d/busy%b exp=1/0", bus.stat, bus.busy); end
        // Reset in the middle of a memory wait.
        start_run();
        bus.icode = 4'd4;
        bus.imem_valid = 1'b1;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL reach_memory got=%b exp=1", bus.mem_req); end
        rst_n = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        total++;
        if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.stat !== 3'd1 || bus.fetch_en !== 1'b0)
            begin bad++; $display("FAIL reset_in_mem got=mem%b/busy%b/stat%0d exp=0/0/1", bus.mem_req, bus.busy, bus.stat); end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int r;
        int w;
        int ic;
        bit ierr, derr, drop;
        do_reset();
        start_run();
        for (int n = 0; n < 40; n++) begin
            r    = $urandom_range(0, 99);
            ierr = (r < 5);
            ic   = (r < 12) ? ((r[0]) ? 0 : $urandom_range(12, 15)) : $urandom_range(1, 11);
            r    = $urandom_range(0, 19);
            w    = (r == 0) ? -1 : (r == 1) ? TIMEOUT - 1 : (r == 2) ? TIMEOUT : $urandom_range(0, 4);
            derr = ($urandom_range(0, 9) == 0);
            drop = ($urandom_range(0, 7) == 0);
            // Linger in FETCH with stray dmem_ready; the controller must wait.
            repeat ($urandom_range(0, 2)) begin
                bus.dmem_ready = ($urandom_range(0, 1) == 1);
                @(negedge clk);
            end
            bus.dmem_ready = 1'b0;
            total++;
            if (bus.fetch_en !== 1'b1) begin bad++; $display("FAIL rnd_wait_fetch n=%0d got=%b exp=1", n, bus.fetch_en); end
            model(ic, ierr, w, derr, e_dec, e_exe, e_mem, e_wb, e_pc, e_lat, e_stat);
            drive_instr(4'(ic), ierr, w, derr, drop, 1'b1);
            total++;
            if (stuck) begin bad++; $display("FAIL rnd_timeout n=%0d got=stuck exp=done", n); end
            total++;
            if (n_dec !== e_dec || n_exe !== e_exe || n_mem !== e_mem || n_wb !== e_wb || n_pc !== e_pc)
                begin bad++; $display("FAIL rnd_stages n=%0d icode=%0d got=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d/%0d", n, ic, n_dec, n_exe, n_mem, n_wb, n_pc, e_dec, e_exe, e_mem, e_wb, e_pc); end
            total++;
            if (lat !== e_lat) begin bad++; $display("FAIL rnd_latency n=%0d icode=%0d got=%0d exp=%0d", n, ic, lat, e_lat); end
            total++;
            if (bus.stat !== 3'(e_stat)) begin bad++; $display("FAIL rnd_stat n=%0d icode=%0d got=%0d exp=%0d", n, ic, bus.stat, e_stat); end
            total++;
            if (n_multi !== 0) begin bad++; $display("FAIL rnd_onehot n=%0d got=%0d exp=0", n, n_multi); end
            if (e_pc == 0) begin
                total++;
                if (bus.busy !== 1'b0) begin bad++; $display("FAIL rnd_terminal_busy n=%0d got=%b exp=0", n, bus.busy); end
                do_reset();
                start_run();
            end else if (drop) begin
                total++;
                if (bus.busy !== 1'b0 || bus.fetch_en !== 1'b0)
                    begin bad++; $display("FAIL rnd_idle n=%0d got=busy%b/fetch%b exp=0/0", n, bus.busy, bus.fetch_en); end
                start_run();
            end
        end
    endtask

`ifdef SEQ_PERF_CNT_EN
    task automatic test_perf();
        int exp_cycles;
        do_reset();
        total++;
        if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0)
            begin bad++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", cycle_cnt, instr_cnt); end
        start_run();
        exp_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            model(6, 0, 0, 0, e_dec, e_exe, e_mem, e_wb, e_pc, e_lat, e_stat);
            exp_cycles += e_lat + 1;   // one FETCH cycle plus the stages to pc_en
            drive_instr(4'd6, 1'b0, 0, 1'b0, (i == 4), 1'b0);
        end
        total++;
        if (instr_cnt !== 32'd5) begin bad++; $display("FAIL perf_instr got=%0d exp=5", instr_cnt); end
        total++;
        if (cycle_cnt !== 32'(exp_cycles)) begin bad++; $display("FAIL perf_cycles got=%0d exp=%0d", cycle_cnt, exp_cycles); end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.icode = 4'd0;
        clear_inputs();
        test_reset();
        test_opq();
        test_mem_wait();
        test_timeout();
        test_terminal();
        test_start_drop();
        test_reset_in_mem();
        test_random();
`ifdef SEQ_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
